// File: rtl/mc_decoder.sv
// Multicycle control unit: Moore main FSM plus combinational ALU and instruction decoders.
// Drives the unconditional write requests and every datapath select/enable.
module mc_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       next_pc_raw;
    logic       ir_write_raw;
    logic       reg_w_raw;
    logic       mem_w_raw;
    logic       branch;
    logic       alu_op;
    logic       alu_cmd_valid;
    logic [1:0] flag_w_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs; UNKNOWN and unused encodings leave everything at zero.
    always_comb begin
        next_pc_raw  = 1'b0;
        ir_write_raw = 1'b0;
        reg_w_raw    = 1'b0;
        mem_w_raw    = 1'b0;
        branch       = 1'b0;
        alu_op       = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = 1'b1;
                next_pc_raw  = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMRD:    AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w_raw = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                mem_w_raw = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            S_ALUWB:    reg_w_raw = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Unrecognised data-processing commands fall back to ADD and never touch the flags.
    always_comb begin
        ALUControl    = 2'b00;
        alu_cmd_valid = 1'b0;
        flag_w_raw    = 2'b00;
        if (alu_op) begin
            alu_cmd_valid = 1'b1;
            case (Funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                default: alu_cmd_valid = 1'b0;
            endcase
            if (alu_cmd_valid) begin
                flag_w_raw = {Funct[0], Funct[0] & ~ALUControl[1]};
            end
        end
    end

    // Strobes are held off while reset is low even though the selects already show FETCH.
    assign NextPC  = reset & next_pc_raw;
    assign IRWrite = reset & ir_write_raw;
    assign RegW    = reset & reg_w_raw;
    assign MemW    = reset & mem_w_raw;
    assign FlagW   = reset ? flag_w_raw : 2'b00;
    assign PCS     = reset & (((Rd == 4'hF) & reg_w_raw) | branch);

    assign ImmSrc  = Op;
    assign RegSrc  = {Op == 2'b01, Op == 2'b10};
    assign State   = state_q;

endmodule

// File: tb/tb_mc_decoder.sv
// Self-checking bench for mc_decoder: directed instruction scenarios plus a randomized
// instruction stream checked cycle by cycle against an instruction-level reference model.
module tb_mc_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic       pcs;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic [1:0] flag_w;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
    } obs_t;

    obs_t obs;
    assign obs = {PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

    obs_t log_out[8];
    int   log_st[8];
    int   log_n;

    mc_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .PCS        (PCS),
        .NextPC     (NextPC),
        .RegW       (RegW),
        .MemW       (MemW),
        .FlagW      (FlagW),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .State      (State)
    );

    always #5 clk = ~clk;

    // Expected outputs for one step of an instruction, from the per-step role table and
    // the data-processing mnemonic (ADD=4, SUB=2, AND=0, ORR=12; S bit = Funct[0]).
    function automatic obs_t model(input int st, input logic [1:0] op,
                                   input logic [5:0] funct, input logic [3:0] rd);
        obs_t e;
        logic known;
        logic arith;
        e = '0;
        known = 1'b0;
        arith = 1'b0;
        e.imm_src = op;
        e.reg_src = {op == 2'b01, op == 2'b10};
        case (st)
            0: begin e.alu_src_a = 1; e.alu_src_b = 2; e.result_src = 2; e.ir_write = 1; e.next_pc = 1; end
            1: begin e.alu_src_a = 1; e.alu_src_b = 2; e.result_src = 2; end
            2: e.alu_src_b = 1;
            3: e.adr_src = 1;
            4: begin e.result_src = 1; e.reg_w = 1; end
            5: begin e.adr_src = 1; e.mem_w = 1; end
            6, 7: begin
                e.alu_src_b = (st == 7) ? 2'd1 : 2'd0;
                case (int'(funct[4:1]))
                    4:  begin e.alu_control = 0; known = 1; arith = 1; end
                    2:  begin e.alu_control = 1; known = 1; arith = 1; end
                    0:  begin e.alu_control = 2; known = 1; end
                    12: begin e.alu_control = 3; known = 1; end
                    default: ;
                endcase
                if (known && funct[0]) e.flag_w = {1'b1, arith};
            end
            8: e.reg_w = 1;
            9: begin e.alu_src_b = 1; e.result_src = 2; e.pcs = 1; end
            default: ;
        endcase
        if (e.reg_w && rd == 4'hF) e.pcs = 1;
        return e;
    endfunction

    // Runs one instruction starting in FETCH (called away from a clock edge); returns in FETCH.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        int   seq[$];
        obs_t expv;
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            2'b01: begin
                seq.push_back(2);
                if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b00: begin seq.push_back(funct[5] ? 7 : 6); seq.push_back(8); end
            2'b10: seq.push_back(9);
            default: seq.push_back(10);
        endcase
        Op = op; Funct = funct; Rd = rd;
        #1;
        log_n = seq.size();
        for (int i = 0; i < seq.size(); i++) begin
            expv = model(seq[i], op, funct, rd);
            checks++;
            if (State !== 4'(seq[i]))
                $display("FAIL state op=%b funct=%b rd=%0d step %0d: got %0d expected %0d",
                         op, funct, rd, i, State, seq[i]);
            else passed++;
            checks++;
            if (obs !== expv)
                $display("FAIL outputs op=%b funct=%b rd=%0d step %0d state %0d: got %h expected %h",
                         op, funct, rd, i, seq[i], obs, expv);
            else passed++;
            log_st[i]  = int'(State);
            log_out[i] = obs;
            @(posedge clk); #1;
        end
        checks++;
        if (State !== 4'd0)
            $display("FAIL return_to_fetch op=%b funct=%b: got %0d expected 0", op, funct, State);
        else passed++;
        $display("instr op=%b funct=%b rd=%0d cycles=%0d", op, funct, rd, seq.size());
    endtask

    task automatic test_reset();
        reset = 1'b0; Op = 2'b00; Funct = 6'b000101; Rd = 4'd2;
        #2;
        checks++;
        if ({State, NextPC, IRWrite, RegW, MemW, PCS, FlagW} !== 11'b0)
            $display("FAIL powerup: got state=%0d strobes=%b expected 0", State,
                     {NextPC, IRWrite, RegW, MemW, PCS, FlagW});
        else passed++;
        @(negedge clk); reset = 1'b1; #1;
        checks++;
        if ({NextPC, IRWrite} !== 2'b11)
            $display("FAIL powerup_release: got NextPC/IRWrite=%b expected 11", {NextPC, IRWrite});
        else passed++;
        // Advance the SUBS into EXECUTER, then yank reset.
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({State, FlagW} !== {4'd6, 2'b11})
            $display("FAIL pre_reset_exec: got state=%0d FlagW=%b expected 6/11", State, FlagW);
        else passed++;
        reset = 1'b0; #1;
        checks++;
        if ({State, NextPC, IRWrite, RegW, MemW, PCS, FlagW} !== 11'b0)
            $display("FAIL midreset_strobes: got state=%0d strobes=%b expected 0", State,
                     {NextPC, IRWrite, RegW, MemW, PCS, FlagW});
        else passed++;
        checks++;
        if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 6'b011010)
            $display("FAIL midreset_selects: got %b expected 011010",
                     {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (State !== 4'd0) $display("FAIL reset_hold: got state %0d expected 0", State);
        else passed++;
        @(negedge clk); reset = 1'b1; #1;
        checks++;
        if ({State, NextPC, IRWrite} !== {4'd0, 2'b11})
            $display("FAIL release_fetch: got state=%0d NextPC/IRWrite=%b expected 0/11",
                     State, {NextPC, IRWrite});
        else passed++;
        @(posedge clk); #1;
        checks++;
        if ({State, NextPC, IRWrite} !== {4'd1, 2'b00})
            $display("FAIL release_decode: got state=%0d NextPC/IRWrite=%b expected 1/00",
                     State, {NextPC, IRWrite});
        else passed++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (State !== 4'd0) $display("FAIL reset_recover: got state %0d expected 0", State);
        else passed++;
        $display("reset scenario done");
    endtask

    task automatic test_ldr();
        logic [7:0] regw_m, pcs_m;
        run_instr(2'b01, 6'b011001, 4'd3);
        regw_m = '0; pcs_m = '0;
        for (int i = 0; i < log_n; i++) begin regw_m[i] = log_out[i].reg_w; pcs_m[i] = log_out[i].pcs; end
        checks++;
        if ({regw_m, pcs_m} !== {8'b0001_0000, 8'b0})
            $display("FAIL ldr_regw_pcs: got regw=%b pcs=%b expected 00010000/0", regw_m, pcs_m);
        else passed++;
        checks++;
        if ({log_st[4], log_out[4].result_src} !== {32'd4, 2'b01})
            $display("FAIL ldr_wb: got state %0d ResultSrc=%b expected 4/01",
                     log_st[4], log_out[4].result_src);
        else passed++;
    endtask

    task automatic test_str();
        logic [7:0] memw_m;
        run_instr(2'b01, 6'b011000, 4'd5);
        memw_m = '0;
        for (int i = 0; i < log_n; i++) memw_m[i] = log_out[i].mem_w;
        checks++;
        if ({memw_m, log_out[3].adr_src} !== {8'b0000_1000, 1'b1})
            $display("FAIL str_memw: got memw=%b AdrSrc=%b expected 00001000/1",
                     memw_m, log_out[3].adr_src);
        else passed++;
    endtask

    task automatic test_subs();
        logic [7:0] flag_m;
        run_instr(2'b00, 6'b000101, 4'd2);
        flag_m = '0;
        for (int i = 0; i < log_n; i++) flag_m[i] = |log_out[i].flag_w;
        checks++;
        if ({log_out[2].alu_control, log_out[2].flag_w} !== 4'b0111)
            $display("FAIL subs_exec: got ALUControl=%b FlagW=%b expected 01/11",
                     log_out[2].alu_control, log_out[2].flag_w);
        else passed++;
        checks++;
        if ({flag_m, log_out[3].reg_w} !== {8'b0000_0100, 1'b1})
            $display("FAIL subs_wb: got flagmask=%b RegW=%b expected 00000100/1",
                     flag_m, log_out[3].reg_w);
        else passed++;
    endtask

    task automatic test_ands_imm();
        run_instr(2'b00, 6'b100001, 4'd15);
        checks++;
        if ({log_out[2].alu_control, log_out[2].flag_w} !== 4'b1010)
            $display("FAIL ands_exec: got ALUControl=%b FlagW=%b expected 10/10",
                     log_out[2].alu_control, log_out[2].flag_w);
        else passed++;
        checks++;
        if ({log_out[3].reg_w, log_out[3].pcs} !== 2'b11)
            $display("FAIL ands_wb_pc: got RegW/PCS=%b expected 11",
                     {log_out[3].reg_w, log_out[3].pcs});
        else passed++;
    endtask

    task automatic test_branch_undef();
        logic [3:0] strobes;
        run_instr(2'b10, 6'($urandom), 4'($urandom));
        checks++;
        if ({log_st[2], log_out[2].pcs} !== {32'd9, 1'b1})
            $display("FAIL branch_pcs: got state %0d PCS=%b expected 9/1", log_st[2], log_out[2].pcs);
        else passed++;
        run_instr(2'b11, 6'($urandom), 4'hF);
        strobes = '0;
        for (int i = 1; i < log_n; i++)
            strobes = strobes | {log_out[i].pcs | log_out[i].next_pc, log_out[i].reg_w | log_out[i].mem_w,
                                 |log_out[i].flag_w, log_out[i].ir_write};
        checks++;
        if ({log_st[2], strobes} !== {32'd10, 4'b0})
            $display("FAIL undef_quiet: got state %0d strobes=%b expected 10/0000", log_st[2], strobes);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] cmds[4] = '{4'd4, 4'd2, 4'd0, 4'd12};
        for (int n = 0; n < 80; n++) begin
            op    = 2'($urandom_range(0, 3));
            funct = 6'($urandom);
            rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 1) == 1) funct[4:1] = cmds[$urandom_range(0, 3)];
            run_instr(op, funct, rd);
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_str();
        test_subs();
        test_ands_imm();
        test_branch_undef();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion expected finish before 1000000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_decoder.md
# mc_decoder

Multicycle control unit for the ARM-subset processor. A Moore main state machine sequences fetch, decode, address, memory, execute and writeback steps. Combinational ALU and instruction decoders run alongside it. The block drives the unconditional write requests (PCS, NextPC, RegW, MemW, FlagW) consumed by the downstream condition logic, plus every datapath mux select and enable.

## Interface
- Parameters: none. The state encoding is fixed and given below.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low. Low forces the state to FETCH.
- Op  in  2  instruction bits [27:26], taken from the instruction register.
- Funct  in  6  instruction bits [25:20].
- Rd  in  4  instruction bits [15:12].
- PCS  out  1  PC-write request from a branch or a write to R15.
- NextPC  out  1  unconditional PC increment.
- RegW, MemW  out  1 each  register-file and memory write requests.
- FlagW  out  2  flag-group write request: [1] = N,Z; [0] = C,V.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  ALU A operand select: 0 = register A, 1 = PC.
- ALUSrcB  out  2  ALU B operand select: 00 = register, 01 = ExtImm, 10 = constant 4.
- ALUControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc, RegSrc  out  2 each  extend select and register-address selects.
- State  out  4  current state encoding, for debug and verification.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- Transitions:
  - FETCH → DECODE.
  - DECODE: Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECUTER; Op=00 with Funct[5]=1 → EXECUTEI; Op=10 → BRANCH; Op=11 → UNKNOWN.
  - MEMADR: Funct[0]=1 → MEMRD, otherwise → MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECUTER and EXECUTEI → ALUWB → FETCH.
  - BRANCH → FETCH.
  - UNKNOWN → FETCH. The instruction is skipped and no write strobes are asserted.
  - Unused encodings 11–15 → FETCH.
- Moore outputs per state; every output not listed is 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode, ALUOp=1:
  - Funct[4:1] selects ALUControl: 0100 → 00, 0010 → 01, 0000 → 10, 1100 → 11. Any other value → 00 with FlagW=00.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (ALUControl is 00 or 01).
- ALU decode, ALUOp=0: ALUControl=00 and FlagW=00.
- PCS = ((Rd==4'hF) & RegW) | Branch.
- ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01).
- This block performs no condition evaluation. All strobes are requests, gated downstream.

## Timing
- The state register updates on the rising edge of clk.
- All outputs are combinational from State and the instruction fields; there are no registered outputs.
- Op, Funct and Rd must be stable from DECODE until the return to FETCH. The instruction register guarantees this by writing only in FETCH.
- Cycles per instruction, counted from FETCH inclusive:
  - LDR: 5.
  - STR: 4.
  - Data-processing: 4.
  - B: 3.
  - Undefined (Op=11): 3.
- Reset behaviour:
  - While reset is low, State=0 (FETCH).
  - NextPC, IRWrite, RegW, MemW, PCS and FlagW are forced to 0; the mux selects show the FETCH values.
  - On the first rising edge after reset goes high, the FETCH strobes take effect.
  - Reset asserted mid-instruction aborts it immediately; no partial writeback occurs after reset is released.
- FlagW is nonzero only in EXECUTER and EXECUTEI.
- RegW is asserted only in MEMWB and ALUWB.
- MemW is asserted only in MEMWR.

## Test plan
- Reset:
  - Stimulus: reset low mid-EXECUTER.
  - Response: State=0 and all strobes 0 immediately. After release, NextPC=1 and IRWrite=1 for one cycle.
- LDR with Op=01, Funct=011001, Rd=3:
  - Response: State sequence 0,1,2,3,4,0.
  - RegW=1 only in state 4, with ResultSrc=01.
  - PCS=0 throughout.
- STR with Op=01, Funct=011000:
  - Response: State sequence 0,1,2,5,0.
  - MemW=1 only in state 5, with AdrSrc=1.
- SUBS with Op=00, Funct=000101, Rd=2:
  - Response: in EXECUTER, ALUControl=01 and FlagW=11.
  - Then ALUWB with RegW=1.
- ANDS immediate with Op=00, Funct=100001, Rd=15:
  - Response: in EXECUTEI, ALUControl=10 and FlagW=10.
  - In ALUWB, RegW=1 and PCS=1.
- B with Op=10, then Op=11:
  - Branch response: State sequence 0,1,9,0 with PCS=1 in state 9.
  - Op=11 response: State sequence 0,1,10,0 with no strobes asserted.
